alu_input_ctrl: RTL and testbench

Operator-side front end for the parameterised ALU on the lab board. It captures operand A, operand B and the opcode from the switches on successive presses of a load button, then drives them to the ALU. One cycle later it registers the ALU result and Z/N/C/V flags and holds them for display until the next press. It is the initiator to the ALU's responder.

---
 rtl/alu_pkg.sv | 39 +++
 rtl/btn_edge.sv | 26 ++
 rtl/alu_input_ctrl.sv | 140 ++++++++++++++
 tb/tb_alu_input_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operator front end: opcodes, FSM states,
// flag bit positions and the opcode acceptance rule.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_DIV  = 4'b0011;
  localparam logic [3:0] OP_MOD  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_SHL  = 4'b0111;
  localparam logic [3:0] OP_SHR  = 4'b1000;
  localparam logic [3:0] OP_XOR  = 4'b1001;
  localparam logic [3:0] OP_LAST = 4'b1001;

  // Bit positions inside the captured {Z,N,C,V} flag vector.
  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic [2:0] {
    S_LOAD_A  = 3'd0,
    S_LOAD_B  = 3'd1,
    S_LOAD_OP = 3'd2,
    S_EXEC    = 3'd3,
    S_SHOW    = 3'd4
  } state_e;

  // An opcode is accepted only if it exists and does not divide by zero.
  function automatic logic op_accept(input logic [3:0] op, input logic b_is_zero);
    logic ok;
    ok = (op <= OP_LAST);
    if ((op == OP_DIV || op == OP_MOD) && b_is_zero) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Two-flop synchronizer followed by a rising-edge detector: one pulse per press.
module btn_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic pulse_o
);

  logic sync1_q, sync2_q, prev_q;

  // Synchronize the raw button and remember the previous synchronized level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign pulse_o = sync2_q & ~prev_q;

endmodule

// File: rtl/alu_input_ctrl.sv
// Operator front end for the lab ALU: captures A, B and opcode from the
// switches on successive load presses, then captures the ALU result and flags.
module alu_input_ctrl
  import alu_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] sw,
  input  logic [3:0]   op_sw,
  input  logic         btn_load,
  input  logic         btn_clr,
  output logic [N-1:0] a,
  output logic [N-1:0] b,
  output logic [3:0]   opCode,
  input  logic [N-1:0] alu_out,
  input  logic         alu_z,
  input  logic         alu_n,
  input  logic         alu_c,
  input  logic         alu_v,
  output logic [N-1:0] result_q,
  output logic [3:0]   flags_q,
  output logic         done,
  output logic         err,
  output logic [2:0]   step
);

  logic load_pulse, clr_pulse;

  state_e       state_q, state_d;
  logic [N-1:0] a_q, a_d, b_q, b_d, result_d;
  logic [3:0]   op_q, op_d, flags_d;
  logic         done_q, done_d, err_q, err_d;

  btn_edge u_load_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_i  (btn_load),
    .pulse_o(load_pulse)
  );

  btn_edge u_clr_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_i  (btn_clr),
    .pulse_o(clr_pulse)
  );

  // State and datapath registers; reset is asynchronous so outputs clear at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_LOAD_A;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      result_q <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Next-state and register updates; clear overrides any load in the same cycle.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    result_d = result_q;
    flags_d  = flags_q;
    done_d   = done_q;
    err_d    = 1'b0;

    if (clr_pulse) begin
      state_d  = S_LOAD_A;
      result_d = '0;
      flags_d  = '0;
      done_d   = 1'b0;
    end else begin
      case (state_q)
        S_LOAD_A: begin
          if (load_pulse) begin
            a_d     = sw;
            state_d = S_LOAD_B;
          end
        end
        S_LOAD_B: begin
          if (load_pulse) begin
            b_d     = sw;
            state_d = S_LOAD_OP;
          end
        end
        S_LOAD_OP: begin
          if (load_pulse) begin
            if (op_accept(op_sw, b_q == '0)) begin
              op_d    = op_sw;
              state_d = S_EXEC;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        S_EXEC: begin
          result_d         = alu_out;
          flags_d[FLAG_Z]  = alu_z;
          flags_d[FLAG_N]  = alu_n;
          flags_d[FLAG_C]  = alu_c;
          flags_d[FLAG_V]  = alu_v;
          done_d           = 1'b1;
          state_d          = S_SHOW;
        end
        S_SHOW: begin
          if (load_pulse) begin
            done_d  = 1'b0;
            state_d = S_LOAD_A;
          end
        end
        default: state_d = S_LOAD_A;
      endcase
    end
  end

  assign a      = a_q;
  assign b      = b_q;
  assign opCode = op_q;
  assign done   = done_q;
  assign err    = err_q;
  assign step   = state_q;

endmodule

// File: tb/tb_alu_input_ctrl.sv
// Directed bench for alu_input_ctrl with a small behavioural ALU in the loop.
module tb_alu_input_ctrl;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] sw, op_sw;
  logic       btn_load, btn_clr;
  logic [3:0] a, b, opCode, alu_out, result_q, flags_q;
  logic       alu_z, alu_n, alu_c, alu_v, done, err;
  logic [2:0] step;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_input_ctrl #(.N(4)) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .op_sw(op_sw),
    .btn_load(btn_load), .btn_clr(btn_clr),
    .a(a), .b(b), .opCode(opCode), .alu_out(alu_out),
    .alu_z(alu_z), .alu_n(alu_n), .alu_c(alu_c), .alu_v(alu_v),
    .result_q(result_q), .flags_q(flags_q), .done(done), .err(err), .step(step)
  );

  // Behavioural ALU: C and V only meaningful for add/sub, C = no-borrow on sub.
  always_comb begin
    logic [4:0] t;
    t     = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (opCode)
      OP_ADD: begin
        t = {1'b0, a} + {1'b0, b};
        alu_c = t[4];
        alu_v = (a[3] == b[3]) && (t[3] != a[3]);
      end
      OP_SUB: begin
        t = {1'b0, a} - {1'b0, b};
        alu_c = (a >= b);
        alu_v = (a[3] != b[3]) && (t[3] != a[3]);
      end
      OP_MUL: t = {1'b0, a * b};
      OP_DIV: t = (b == 0) ? 5'd0 : {1'b0, a / b};
      OP_MOD: t = (b == 0) ? 5'd0 : {1'b0, a % b};
      OP_AND: t = {1'b0, a & b};
      OP_OR:  t = {1'b0, a | b};
      OP_SHL: t = {1'b0, a << 1};
      OP_SHR: t = {1'b0, a >> 1};
      OP_XOR: t = {1'b0, a ^ b};
      default: t = '0;
    endcase
    alu_out = t[3:0];
    alu_z   = (t[3:0] == 4'd0);
    alu_n   = t[3];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Press load; returns at the negedge just after the edge that acts on it.
  task automatic load_down(input logic [3:0] s, input logic [3:0] o);
    @(negedge clk);
    sw = s; op_sw = o; btn_load = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic load_up();
    btn_load = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] s, input logic [3:0] o);
    load_down(s, o);
    load_up();
  endtask

  task automatic clr_press();
    @(negedge clk);
    btn_clr = 1'b1;
    repeat (3) @(negedge clk);
    btn_clr = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int transitions;
    logic [2:0] last_step;
    rst_n = 1'b0; sw = '0; op_sw = '0; btn_load = 1'b0; btn_clr = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_step", step, 0);
    check_eq("rst_a", a, 0);
    check_eq("rst_result", result_q, 0);
    check_eq("rst_done", done, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // ADD 3 + 2
    press(4'd3, 4'd0);
    check_eq("add_step_b", step, 1);
    check_eq("add_a", a, 3);
    press(4'd2, 4'd0);
    check_eq("add_step_op", step, 2);
    check_eq("add_b", b, 2);
    load_down(4'd0, OP_ADD);
    check_eq("add_exec_step", step, 3);
    check_eq("add_exec_done", done, 0);
    @(negedge clk);
    check_eq("add_show_step", step, 4);
    check_eq("add_done", done, 1);
    check_eq("add_result", result_q, 5);
    check_eq("add_flags", flags_q, 4'b0000);
    load_up();

    // SUB 2 - 3
    press(4'd0, 4'd0);
    check_eq("show_exit_step", step, 0);
    check_eq("show_exit_done", done, 0);
    press(4'd2, 4'd0);
    press(4'd3, 4'd0);
    press(4'd0, OP_SUB);
    check_eq("sub_result", result_q, 4'hF);
    check_eq("sub_flags", flags_q, 4'b0100);
    check_eq("sub_done", done, 1);

    // Invalid opcode, then a legal one
    press(4'd0, 4'd0);
    press(4'd5, 4'd0);
    press(4'd6, 4'd0);
    load_down(4'd0, 4'b1100);
    check_eq("badop_err", err, 1);
    check_eq("badop_step", step, 2);
    check_eq("badop_opcode", opCode, OP_SUB);
    @(negedge clk);
    check_eq("badop_err_low", err, 0);
    load_up();
    press(4'd0, OP_SHL);
    check_eq("shl_step", step, 4);
    check_eq("shl_result", result_q, 4'hA);
    check_eq("shl_flags", flags_q, 4'b0100);

    // Divide / modulo by zero rejected
    press(4'd0, 4'd0);
    press(4'd7, 4'd0);
    press(4'd0, 4'd0);
    load_down(4'd0, OP_DIV);
    check_eq("div0_err", err, 1);
    check_eq("div0_step", step, 2);
    load_up();
    check_eq("div0_err_low", err, 0);
    load_down(4'd0, OP_MOD);
    check_eq("mod0_err", err, 1);
    check_eq("mod0_step", step, 2);
    check_eq("mod0_opcode", opCode, OP_SHL);
    load_up();
    clr_press();
    check_eq("clr_step", step, 0);

    // Held button gives exactly one transition
    @(negedge clk);
    sw = 4'd4; btn_load = 1'b1;
    transitions = 0;
    last_step = step;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (step != last_step) transitions++;
      last_step = step;
    end
    check_eq("hold_transitions", transitions, 1);
    check_eq("hold_step", step, 1);
    load_up();
    press(4'd1, 4'd0);
    press(4'd0, OP_ADD);
    check_eq("hold_add_result", result_q, 5);

    // Clear and load together in S_SHOW: clear wins
    @(negedge clk);
    btn_load = 1'b1; btn_clr = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("clrld_step", step, 0);
    check_eq("clrld_done", done, 0);
    check_eq("clrld_result", result_q, 0);
    check_eq("clrld_flags", flags_q, 0);
    check_eq("clrld_a_kept", a, 4);
    btn_load = 1'b0; btn_clr = 1'b0;
    repeat (2) @(negedge clk);

    // Asynchronous reset during S_EXEC
    press(4'd1, 4'd0);
    press(4'd1, 4'd0);
    load_down(4'd0, OP_ADD);
    check_eq("pre_rst_step", step, 3);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_step", step, 0);
    check_eq("arst_a", a, 0);
    check_eq("arst_b", b, 0);
    check_eq("arst_op", opCode, 0);
    check_eq("arst_result", result_q, 0);
    check_eq("arst_done", done, 0);
    btn_load = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    press(4'd9, 4'd0);
    check_eq("post_rst_step", step, 1);
    check_eq("post_rst_a", a, 9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
